// File: rtl/aig_eval_engine_if.sv
// Control and streaming bus of the AIG evaluation engine: run control,
// variable load channel, node descriptor channel and result outputs.
interface aig_eval_engine_if #(
  parameter int LANES = 8,
  parameter int IDX_W = 7
);
  logic             start;
  logic [IDX_W-1:0] out_idx;
  logic             out_inv;
  logic             var_valid;
  logic             var_ready;
  logic [LANES-1:0] var_data;
  logic             node_valid;
  logic             node_ready;
  logic [IDX_W-1:0] node_a_idx;
  logic [IDX_W-1:0] node_b_idx;
  logic             node_a_inv;
  logic             node_b_inv;
  logic             node_last;
  logic             busy;
  logic             done;
  logic [LANES-1:0] z;
  logic             err;

  modport master (
    output start, out_idx, out_inv, var_valid, var_data,
           node_valid, node_a_idx, node_b_idx, node_a_inv, node_b_inv, node_last,
    input  var_ready, node_ready, busy, done, z, err
  );

  modport slave (
    input  start, out_idx, out_inv, var_valid, var_data,
           node_valid, node_a_idx, node_b_idx, node_a_inv, node_b_inv, node_last,
    output var_ready, node_ready, busy, done, z, err
  );
endinterface

// File: rtl/aig_eval_engine.sv
// Bit-parallel And-Inverter-Graph evaluator: loads LANES-wide primary input
// patterns, streams AND nodes one per cycle, then reports one output literal.
module aig_eval_engine #(
  parameter int VAR_COUNT = 32,
  parameter int NODE_MAX  = 64,
  parameter int LANES     = 8,
  parameter int IDX_W     = $clog2(VAR_COUNT + NODE_MAX + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  aig_eval_engine_if.slave   bus
);
  localparam int LAST_IDX = VAR_COUNT + NODE_MAX;
  localparam int CW       = IDX_W + 1;
  localparam logic [CW-1:0]    LAST_VAR   = CW'(VAR_COUNT);
  localparam logic [CW-1:0]    OVF_CNT    = CW'(LAST_IDX + 1);
  localparam logic [IDX_W-1:0] LAST_IDX_W = IDX_W'(LAST_IDX);

  typedef enum logic [1:0] {IDLE, LOAD, EVAL, FINISH} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [IDX_W-1:0] outIdx_q;
  logic             outInv_q;
  logic             varReady_q;
  logic             nodeReady_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic [LANES-1:0] z_q;
  logic [LANES-1:0] store_q [0:LAST_IDX];

  logic             varFire, nodeFire, overflow, nodeBad, outBad, storeWe;
  logic [CW-1:0]    nextCnt, finalCnt;
  logic [IDX_W-1:0] wrAddr;
  logic [LANES-1:0] wrData, nodeVal, zVal;

  // Index 0 and unreachable indices read as constant false.
  function automatic logic [LANES-1:0] readLit(input logic [IDX_W-1:0] idx, input logic inv);
    logic [LANES-1:0] v;
    v = '0;
    if (idx != '0 && idx <= LAST_IDX_W) v = store_q[idx];
    return v ^ {LANES{inv}};
  endfunction

  always_comb begin
    varFire  = bus.var_valid & varReady_q;
    nodeFire = bus.node_valid & nodeReady_q;
    overflow = (cnt_q == OVF_CNT);
    nextCnt  = cnt_q + CW'(1);
    finalCnt = overflow ? cnt_q : nextCnt;
    nodeBad  = ({1'b0, bus.node_a_idx} >= cnt_q) | ({1'b0, bus.node_b_idx} >= cnt_q);
    nodeVal  = nodeBad ? '0 : (readLit(bus.node_a_idx, bus.node_a_inv) &
                               readLit(bus.node_b_idx, bus.node_b_inv));
    outBad   = ({1'b0, outIdx_q} >= finalCnt);
    // The output may name the node written in this very cycle, so forward it.
    zVal     = '0;
    if (!outBad) begin
      if ({1'b0, outIdx_q} == cnt_q) zVal = nodeVal ^ {LANES{outInv_q}};
      else                           zVal = readLit(outIdx_q, outInv_q);
    end
    storeWe = 1'b0;
    wrAddr  = cnt_q[IDX_W-1:0];
    wrData  = bus.var_data;
    if (state_q == LOAD && varFire) begin
      storeWe = 1'b1;
    end else if (state_q == EVAL && nodeFire && !overflow) begin
      storeWe = 1'b1;
      wrData  = nodeVal;
    end
  end

  always_ff @(posedge clk) begin
    if (storeWe) store_q[wrAddr] <= wrData;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      outIdx_q    <= '0;
      outInv_q    <= 1'b0;
      varReady_q  <= 1'b0;
      nodeReady_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      z_q         <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            outIdx_q   <= bus.out_idx;
            outInv_q   <= bus.out_inv;
            err_q      <= 1'b0;
            cnt_q      <= CW'(1);
            varReady_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= LOAD;
          end
        end
        LOAD: begin
          if (varFire) begin
            cnt_q <= nextCnt;
            if (cnt_q == LAST_VAR) begin
              varReady_q  <= 1'b0;
              nodeReady_q <= 1'b1;
              state_q     <= EVAL;
            end
          end
        end
        EVAL: begin
          if (nodeFire) begin
            cnt_q <= finalCnt;
            // Result and done are registered on the closing handshake itself.
            if (overflow || bus.node_last) begin
              nodeReady_q <= 1'b0;
              done_q      <= 1'b1;
              z_q         <= zVal;
              err_q       <= err_q | overflow | nodeBad | outBad;
              state_q     <= FINISH;
            end else begin
              err_q <= err_q | nodeBad;
            end
          end
        end
        FINISH: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.var_ready  = varReady_q;
  assign bus.node_ready = nodeReady_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.z          = z_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_aig_eval_engine.sv
// Directed bench for aig_eval_engine: a graph-level reference model predicts
// z/err/done timing, and a per-cycle compare process checks the DUT against it.
module tb_aig_eval_engine;
  localparam int VC = 3;
  localparam int NM = 2;
  localparam int LN = 4;
  localparam int IW = $clog2(VC + NM + 1);

  typedef struct {
    int a;
    bit ai;
    int b;
    bit bi;
    bit last;
  } node_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aig_eval_engine_if #(.LANES(LN), .IDX_W(IW)) bus ();

  aig_eval_engine #(.VAR_COUNT(VC), .NODE_MAX(NM), .LANES(LN), .IDX_W(IW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int finalEdgeCyc = -1;
  bit doneSeen = 1'b0;
  bit cmpEn = 1'b0;
  logic [LN-1:0] varVals [1:VC];
  node_t nodes[$];
  logic [LN-1:0] expZ;
  bit expErr;
  int expNodes;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // done must appear exactly in the cycle after the closing handshake, with model z/err.
  always @(negedge clk) begin
    if (cmpEn) begin
      checkOutput("done_timing", 32'(bus.done), 32'(cyc == finalEdgeCyc));
      if (bus.done) begin
        doneSeen = 1'b1;
        checkOutput("model_z", 32'(bus.z), 32'(expZ));
        checkOutput("model_err", 32'(bus.err), 32'(expErr));
      end
    end
  end

  // Graph-level evaluation of the node list with the run's output literal.
  task automatic computeModel(input int oi, input bit oinv);
    logic [LN-1:0] val [0:15];
    int k;
    bit stop;
    for (int i = 0; i < 16; i++) val[i] = '0;
    for (int v = 1; v <= VC; v++) val[v] = varVals[v];
    expErr = 1'b0;
    expNodes = 0;
    k = VC + 1;
    stop = 1'b0;
    for (int i = 0; i < nodes.size() && !stop; i++) begin
      expNodes++;
      if (k > VC + NM) begin
        expErr = 1'b1;
        stop = 1'b1;
      end else begin
        if (nodes[i].a >= k || nodes[i].b >= k) begin
          expErr = 1'b1;
          val[k] = '0;
        end else begin
          val[k] = (val[nodes[i].a] ^ {LN{nodes[i].ai}}) & (val[nodes[i].b] ^ {LN{nodes[i].bi}});
        end
        k++;
        if (nodes[i].last) stop = 1'b1;
      end
    end
    if (oi >= k) begin
      expErr = 1'b1;
      expZ = '0;
    end else begin
      expZ = val[oi] ^ {LN{oinv}};
    end
  endtask

  task automatic addNode(input int a, input bit ai, input int b, input bit bi, input bit last);
    node_t n;
    n.a = a; n.ai = ai; n.b = b; n.bi = bi; n.last = last;
    nodes.push_back(n);
  endtask

  task automatic setGraphMain();
    nodes.delete();
    addNode(1, 1'b0, 2, 1'b0, 1'b0);
    addNode(4, 1'b1, 3, 1'b0, 1'b1);
  endtask

  task automatic startRun(input int oi, input bit oinv);
    computeModel(oi, oinv);
    finalEdgeCyc = -1;
    doneSeen = 1'b0;
    bus.out_idx = IW'(oi);
    bus.out_inv = oinv;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic loadVars();
    int guard;
    logic hs;
    for (int v = 1; v <= VC; v++) begin
      bus.var_valid = 1'b1;
      bus.var_data = varVals[v];
      guard = 0;
      hs = 1'b0;
      while (!hs && guard < 20) begin
        hs = bus.var_ready;
        guard++;
        @(posedge clk); #1;
      end
      checkOutput("var_handshake", 32'(hs), 32'd1);
    end
    bus.var_valid = 1'b0;
  endtask

  task automatic driveNode(input int i);
    bus.node_a_idx = IW'(nodes[i].a);
    bus.node_a_inv = nodes[i].ai;
    bus.node_b_idx = IW'(nodes[i].b);
    bus.node_b_inv = nodes[i].bi;
    bus.node_last  = nodes[i].last;
    bus.node_valid = 1'b1;
  endtask

  task automatic streamNodes(input bit gaps, input bit startNoise);
    int sent;
    int guard;
    logic hs;
    sent = 0;
    guard = 0;
    while (sent < expNodes && guard < 100) begin
      guard++;
      if (startNoise) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.out_idx = IW'($urandom_range(0, 6));
        bus.out_inv = 1'($urandom_range(0, 1));
      end
      if (gaps && $urandom_range(0, 2) == 0) bus.node_valid = 1'b0;
      else driveNode(sent);
      hs = bus.node_valid & bus.node_ready;
      @(posedge clk); #1;
      if (hs) begin
        sent++;
        if (sent == expNodes) finalEdgeCyc = cyc;
      end
    end
    bus.node_valid = 1'b0;
    bus.start = 1'b0;
    checkOutput("node_stream_complete", 32'(sent), 32'(expNodes));
  endtask

  task automatic waitDone();
    for (int i = 0; i < 6 && !doneSeen; i++) @(posedge clk);
    #1;
    checkOutput("done_seen", 32'(doneSeen), 32'd1);
  endtask

  task automatic applyStimulus(input int oi, input bit oinv, input bit gaps, input bit startNoise);
    startRun(oi, oinv);
    loadVars();
    streamNodes(gaps, startNoise);
    waitDone();
  endtask

  initial begin
    bus.start = 1'b0; bus.out_idx = '0; bus.out_inv = 1'b0;
    bus.var_valid = 1'b0; bus.var_data = '0;
    bus.node_valid = 1'b0; bus.node_a_idx = '0; bus.node_b_idx = '0;
    bus.node_a_inv = 1'b0; bus.node_b_inv = 1'b0; bus.node_last = 1'b0;
    varVals[1] = 4'b1100; varVals[2] = 4'b1010; varVals[3] = 4'b1111;

    repeat (3) @(posedge clk); #1;
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_var_ready", 32'(bus.var_ready), 32'd0);
    checkOutput("rst_node_ready", 32'(bus.node_ready), 32'd0);
    checkOutput("rst_z", 32'(bus.z), 32'd0);
    checkOutput("rst_err", 32'(bus.err), 32'd0);
    rst_n = 1'b1;
    cmpEn = 1'b1;
    @(posedge clk); #1;

    $display("[TB] main graph, out=5");
    setGraphMain();
    applyStimulus(5, 1'b0, 1'b0, 1'b0);
    checkOutput("main_z_literal", 32'(bus.z), 32'b0111);
    checkOutput("main_err_literal", 32'(bus.err), 32'd0);
    @(posedge clk); #1;
    checkOutput("idle_busy", 32'(bus.busy), 32'd0);

    $display("[TB] out=~4 and out=~0");
    applyStimulus(4, 1'b1, 1'b0, 1'b0);
    checkOutput("inv4_z_literal", 32'(bus.z), 32'b0111);
    applyStimulus(0, 1'b1, 1'b0, 1'b0);
    checkOutput("inv0_z_literal", 32'(bus.z), 32'b1111);
    checkOutput("inv0_err_literal", 32'(bus.err), 32'd0);

    $display("[TB] output index beyond last node");
    applyStimulus(6, 1'b0, 1'b0, 1'b0);
    checkOutput("oor_z_literal", 32'(bus.z), 32'd0);
    checkOutput("oor_err_literal", 32'(bus.err), 32'd1);

    $display("[TB] self-referencing node");
    nodes.delete();
    addNode(4, 1'b0, 1, 1'b0, 1'b1);
    applyStimulus(4, 1'b0, 1'b0, 1'b0);
    checkOutput("selfref_z_literal", 32'(bus.z), 32'd0);
    checkOutput("selfref_err_literal", 32'(bus.err), 32'd1);

    $display("[TB] node overflow");
    nodes.delete();
    addNode(1, 1'b0, 2, 1'b0, 1'b0);
    addNode(4, 1'b0, 3, 1'b0, 1'b0);
    addNode(5, 1'b0, 1, 1'b0, 1'b0);
    applyStimulus(5, 1'b0, 1'b0, 1'b0);
    checkOutput("ovf_z_literal", 32'(bus.z), 32'b1000);
    checkOutput("ovf_err_literal", 32'(bus.err), 32'd1);
    driveNode(0);
    @(posedge clk); #1;
    checkOutput("ovf_node_ready_low", 32'(bus.node_ready), 32'd0);
    bus.node_valid = 1'b0;

    $display("[TB] reset mid-evaluation");
    setGraphMain();
    startRun(5, 1'b0);
    loadVars();
    driveNode(0);
    @(posedge clk); #1;
    driveNode(1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
    checkOutput("midrst_node_ready", 32'(bus.node_ready), 32'd0);
    checkOutput("midrst_var_ready", 32'(bus.var_ready), 32'd0);
    checkOutput("midrst_z", 32'(bus.z), 32'd0);
    checkOutput("midrst_err", 32'(bus.err), 32'd0);
    rst_n = 1'b1;
    bus.node_valid = 1'b0;
    @(posedge clk); #1;
    applyStimulus(5, 1'b0, 1'b0, 1'b0);
    checkOutput("postrst_z_literal", 32'(bus.z), 32'b0111);

    $display("[TB] start noise and valid gaps during evaluation");
    applyStimulus(5, 1'b0, 1'b1, 1'b1);
    checkOutput("noise_z_literal", 32'(bus.z), 32'b0111);
    checkOutput("noise_err_literal", 32'(bus.err), 32'd0);

    repeat (3) @(posedge clk);
    cmpEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
